multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Moore control FSM for the multicycle MIPS datapath (shared memory, IR, PC). Sequences
//  FETCH/DECODE/execute/writeback per opcode and generates all datapath mux selects and
//  write enables. Adds configurable memory wait-states, optional ADDI/J support and
//  illegal-opcode trapping. The ALU decoder (funct -> alucontrol) stays a separate block.
// PARAMETERS
//  MEM_LATENCY   1  cycles each memory state (FETCH/MEMRD/MEMWR) is held; legal 1..15
//  ENABLE_ADDI   1  0: ADDI (001000) is treated as illegal
//  ENABLE_JUMP   1  0: J (000010) is treated as illegal
//  ILLEGAL_HALT  1  1: ILLEGAL is sticky until reset; 0: one-cycle NOP, then FETCH
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  synchronous, active-high
//  op          in   6  instr[31:26] from IR; valid from DECODE onward
//  pcwrite     out  1  unconditional PC write
//  branch      out  1  conditional PC write (datapath ANDs with zero)
//  iord        out  1  memory address: 0=PC, 1=ALUOut
//  memwrite    out  1  memory write enable
//  irwrite     out  1  IR load enable
//  regwrite    out  1  register-file write enable
//  regdst      out  1  write reg: 0=rt, 1=rd
//  memtoreg    out  1  write data: 0=ALUOut, 1=Data
//  alusrca     out  1  0=PC, 1=A
//  alusrcb     out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  pcsrc       out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  aluop       out  2  00=add, 01=sub, 10=funct
//  illegal_op  out  1  high in ILLEGAL
//  instr_done  out  1  one-cycle pulse on last cycle of each instruction
//  state       out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTE=6 ALUWB=7
//   BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11 ILLEGAL=12; 13-15 unreachable -> FETCH.
//  Reset: next edge state=FETCH, wait_cnt=0. While reset high, all enables (pcwrite,
//   irwrite, memwrite, regwrite, branch, instr_done, illegal_op) forced 0; selects = FETCH.
//  wait_cnt: cleared on entry to any memory state; "last" = (wait_cnt==MEM_LATENCY-1).
//   A memory state exits only on its last cycle; otherwise it holds and increments.
//  Outputs per state (unlisted = 0):
//   FETCH:   alusrcb=01; irwrite,pcwrite only on last cycle -> DECODE
//   DECODE:  alusrcb=11 -> by op: 100011/101011 MEMADR, 000000 EXECUTE, 000100 BRANCH,
//            001000 ADDIEX, 000010 JUMP, other/disabled ILLEGAL
//   MEMADR:  alusrca=1, alusrcb=10 -> lw MEMRD, sw MEMWR
//   MEMRD:   iord=1 -> MEMWB on last      MEMWB:  memtoreg=1, regwrite=1 -> FETCH
//   MEMWR:   iord=1, memwrite=1 every cycle held -> FETCH on last
//   EXECUTE: alusrca=1, aluop=10 -> ALUWB ALUWB: regdst=1, regwrite=1 -> FETCH
//   BRANCH:  alusrca=1, aluop=01, branch=1, pcsrc=01 -> FETCH
//   ADDIEX:  alusrca=1, alusrcb=10 -> ADDIWB   ADDIWB: regwrite=1 -> FETCH
//   JUMP:    pcsrc=10, pcwrite=1 -> FETCH
//   ILLEGAL: illegal_op=1, all enables 0; ILLEGAL_HALT ? stay : -> FETCH
//  instr_done=1 in MEMWB, ALUWB, BRANCH, ADDIWB, JUMP and last cycle of MEMWR.
//  Cycles/instr, L=MEM_LATENCY: lw 3+2L, sw 2+2L, R 3+L, beq 2+L, addi 3+L, j 2+L.
//  op sampled only in DECODE/MEMADR; changes elsewhere ignored. Never regwrite and
//   memwrite together; pcwrite never asserted outside FETCH last cycle and JUMP.
// TESTING
//  L=1, reset 2 cycles, op=000000 -> states 0,1,6,7,0; regwrite+regdst in ALUWB; done@4th
//  L=3, op=100011 -> FETCH 3 cyc (irwrite only 3rd), MEMRD 3 cyc iord=1, MEMWB; 9 cycles
//  L=2, op=101011 -> memwrite high exactly 2 cycles in MEMWR, instr_done on 2nd, regwrite=0
//  ENABLE_ADDI=0, op=001000 -> ILLEGAL; HALT=1 stays until reset; HALT=0 FETCH next cycle
//  L=3, reset asserted on 2nd MEMRD cycle -> no enables while high, FETCH with wait_cnt=0
//  op=000100 then 000010 -> BRANCH branch=1,pcsrc=01; JUMP pcwrite=1,pcsrc=10; 3 cyc each

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle MIPS datapath. Moore machine that sequences
// fetch/decode/execute/writeback per opcode, with memory wait-states, optional ADDI/J
// support and illegal-opcode trapping. Outputs depend only on the current state, except
// that reset forces every enable low and the selects to their FETCH values.
module multicycle_main_fsm #(
   parameter int unsigned MEM_LATENCY  = 1,    // cycles per memory state, 1..15
   parameter bit          ENABLE_ADDI  = 1'b1,
   parameter bit          ENABLE_JUMP  = 1'b1,
   parameter bit          ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   output logic       pcwrite,
   output logic       branch,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       illegal_op,
   output logic       instr_done,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11,
      StIllegal = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

   state_e     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       in_mem_state;
   logic       last;

   assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   assign last         = (wait_cnt_q == LastCnt);
   assign state        = state_q;

   // State and wait-state counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StFetch;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state selection; memory states hold until their last wait cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:   if (last) state_d = StDecode;
         StDecode: begin
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExecute;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = ENABLE_ADDI ? StAddiEx : StIllegal;
               OpJ:        state_d = ENABLE_JUMP ? StJump : StIllegal;
               default:    state_d = StIllegal;
            endcase
         end
         StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
         StMemRd:   if (last) state_d = StMemWb;
         StMemWb:   state_d = StFetch;
         StMemWr:   if (last) state_d = StFetch;
         StExecute: state_d = StAluWb;
         StAluWb:   state_d = StFetch;
         StBranch:  state_d = StFetch;
         StAddiEx:  state_d = StAddiWb;
         StAddiWb:  state_d = StFetch;
         StJump:    state_d = StFetch;
         StIllegal: state_d = ILLEGAL_HALT ? StIllegal : StFetch;
         default:   state_d = StFetch;
      endcase
   end

   // Counter advances only while a memory state is held; any transition clears it.
   always_comb begin
      wait_cnt_d = 4'd0;
      if (in_mem_state && (state_d == state_q)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   // Moore output decode, overridden to idle FETCH values while reset is high.
   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = 2'b00;
      illegal_op = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         StFetch: begin
            alusrcb = 2'b01;
            irwrite = last;
            pcwrite = last;
         end
         StDecode:  alusrcb = 2'b11;
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         StMemRd:   iord = 1'b1;
         StMemWb: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         StMemWr: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = last;
         end
         StExecute: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         StAluWb: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         StBranch: begin
            alusrca    = 1'b1;
            aluop      = 2'b01;
            branch     = 1'b1;
            pcsrc      = 2'b01;
            instr_done = 1'b1;
         end
         StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         StAddiWb: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         StJump: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
         end
         StIllegal: illegal_op = 1'b1;
         default: ;
      endcase
      if (reset) begin
         pcwrite    = 1'b0;
         branch     = 1'b0;
         iord       = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 1'b0;
         regwrite   = 1'b0;
         regdst     = 1'b0;
         memtoreg   = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = 2'b01;
         pcsrc      = 2'b00;
         aluop      = 2'b00;
         illegal_op = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm. Three instances with different latency/feature
// settings are exercised one at a time; a per-instruction cycle schedule is derived from
// the opcode's behaviour and compared against every output on every cycle.
module tb_multicycle_main_fsm;

   // Per-instance settings, instance k in field/bit k.
   localparam logic [11:0] LATS  = {4'd2, 4'd1, 4'd3};
   localparam logic [2:0]  EADDI = 3'b001;
   localparam logic [2:0]  EJMP  = 3'b011;
   localparam logic [2:0]  HALT  = 3'b101;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   // Enable flag positions inside the 9-bit enable/select field.
   localparam logic [8:0] PCW  = 9'b100000000;
   localparam logic [8:0] BR   = 9'b010000000;
   localparam logic [8:0] IORD = 9'b001000000;
   localparam logic [8:0] MW   = 9'b000100000;
   localparam logic [8:0] IRW  = 9'b000010000;
   localparam logic [8:0] RW   = 9'b000001000;
   localparam logic [8:0] RD   = 9'b000000100;
   localparam logic [8:0] M2R  = 9'b000000010;
   localparam logic [8:0] ASA  = 9'b000000001;

   logic        clk = 1'b0;
   logic [2:0]  rst_s;
   logic [17:0] op_all;
   wire  [62:0] obs_all;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [20:0] v;
      logic        real_op;
   } exp_t;
   exp_t sched[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      multicycle_main_fsm #(
         .MEM_LATENCY (int'(LATS[g*4 +: 4])),
         .ENABLE_ADDI (EADDI[g]),
         .ENABLE_JUMP (EJMP[g]),
         .ILLEGAL_HALT(HALT[g])
      ) u_dut (
         .clk       (clk),
         .reset     (rst_s[g]),
         .op        (op_all[g*6 +: 6]),
         .pcwrite   (obs_all[g*21 + 20]),
         .branch    (obs_all[g*21 + 19]),
         .iord      (obs_all[g*21 + 18]),
         .memwrite  (obs_all[g*21 + 17]),
         .irwrite   (obs_all[g*21 + 16]),
         .regwrite  (obs_all[g*21 + 15]),
         .regdst    (obs_all[g*21 + 14]),
         .memtoreg  (obs_all[g*21 + 13]),
         .alusrca   (obs_all[g*21 + 12]),
         .alusrcb   (obs_all[g*21 + 10 +: 2]),
         .pcsrc     (obs_all[g*21 + 8 +: 2]),
         .aluop     (obs_all[g*21 + 6 +: 2]),
         .illegal_op(obs_all[g*21 + 5]),
         .instr_done(obs_all[g*21 + 4]),
         .state     (obs_all[g*21 +: 4])
      );
   end

   // Expected output word: {enables, alusrcb, pcsrc, aluop, illegal_op, instr_done, state}.
   function automatic logic [20:0] o(input int st, input logic [1:0] b, input logic [1:0] ps,
                                     input logic [1:0] ao, input logic [8:0] en,
                                     input logic ill, input logic dn);
      return {en, b, ps, ao, ill, dn, 4'(st)};
   endfunction

   function automatic void push(input logic [20:0] v, input logic r);
      exp_t e;
      e.v       = v;
      e.real_op = r;
      sched.push_back(e);
   endfunction

   // Builds the cycle-by-cycle schedule of one instruction; returns 1 if it halts.
   function automatic bit build(input int k, input logic [5:0] opc);
      int unsigned l;
      l = int'(LATS[k*4 +: 4]);
      sched.delete();
      for (int unsigned i = 0; i < l; i++)
         push(o(0, 2'b01, 2'b00, 2'b00, (i == l - 1) ? (PCW | IRW) : 9'b0, 1'b0, 1'b0), 1'b0);
      push(o(1, 2'b11, 2'b00, 2'b00, 9'b0, 1'b0, 1'b0), 1'b1);
      if (opc == OP_LW) begin
         push(o(2, 2'b10, 2'b00, 2'b00, ASA, 1'b0, 1'b0), 1'b1);
         for (int unsigned i = 0; i < l; i++)
            push(o(3, 2'b00, 2'b00, 2'b00, IORD, 1'b0, 1'b0), 1'b0);
         push(o(4, 2'b00, 2'b00, 2'b00, M2R | RW, 1'b0, 1'b1), 1'b0);
      end else if (opc == OP_SW) begin
         push(o(2, 2'b10, 2'b00, 2'b00, ASA, 1'b0, 1'b0), 1'b1);
         for (int unsigned i = 0; i < l; i++)
            push(o(5, 2'b00, 2'b00, 2'b00, IORD | MW, 1'b0, i == l - 1), 1'b0);
      end else if (opc == OP_R) begin
         push(o(6, 2'b00, 2'b00, 2'b10, ASA, 1'b0, 1'b0), 1'b0);
         push(o(7, 2'b00, 2'b00, 2'b00, RD | RW, 1'b0, 1'b1), 1'b0);
      end else if (opc == OP_BEQ) begin
         push(o(8, 2'b00, 2'b01, 2'b01, ASA | BR, 1'b0, 1'b1), 1'b0);
      end else if (opc == OP_ADDI && EADDI[k]) begin
         push(o(9, 2'b10, 2'b00, 2'b00, ASA, 1'b0, 1'b0), 1'b0);
         push(o(10, 2'b00, 2'b00, 2'b00, RW, 1'b0, 1'b1), 1'b0);
      end else if (opc == OP_J && EJMP[k]) begin
         push(o(11, 2'b00, 2'b10, 2'b00, PCW, 1'b0, 1'b1), 1'b0);
      end else begin
         push(o(12, 2'b00, 2'b00, 2'b00, 9'b0, 1'b1, 1'b0), 1'b0);
         if (HALT[k]) begin
            for (int i = 0; i < 3; i++) push(o(12, 2'b00, 2'b00, 2'b00, 9'b0, 1'b1, 1'b0), 1'b0);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Drives one cycle of inputs, checks outputs, then advances to 1 time unit past the edge.
   task automatic step(input int k, input logic [20:0] exp, input logic [5:0] opv,
                       input logic rst, input bit chk, input string tag);
      logic [20:0] got;
      rst_s[k]           = rst;
      op_all[k*6 +: 6]   = opv;
      #1;
      got = obs_all[k*21 +: 21];
      if (chk) begin
         checks++;
         assert (got === exp)
         else begin
            errors++;
            $error("FAIL %s dut%0d: observed=%h expected=%h", tag, k, got, exp);
         end
      end
      checks++;
      assert (!(got[15] && got[17]))
      else begin
         errors++;
         $error("FAIL %s_rw_mw dut%0d: observed=%h expected=no regwrite+memwrite", tag, k, got);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int k, input int prev);
      step(k, o(prev, 2'b01, 2'b00, 2'b00, 9'b0, 1'b0, 1'b0), 6'($urandom_range(0, 63)), 1'b1,
           prev >= 0, "reset_a");
      step(k, o(0, 2'b01, 2'b00, 2'b00, 9'b0, 1'b0, 1'b0), 6'($urandom_range(0, 63)), 1'b1,
           1'b1, "reset_b");
   endtask

   task automatic run_instr(input int k, input logic [5:0] opc);
      bit halted;
      logic [5:0] opv;
      halted = build(k, opc);
      for (int i = 0; i < sched.size(); i++) begin
         opv = sched[i].real_op ? opc : 6'($urandom_range(0, 63));
         step(k, sched[i].v, opv, 1'b0, 1'b1, $sformatf("op%b_c%0d", opc, i));
      end
      if (halted) do_reset(k, 12);
   endtask

   task automatic run_random(input int k, input int n);
      logic [5:0] opc;
      for (int j = 0; j < n; j++) begin
         case ($urandom_range(0, 6))
            0:       opc = OP_LW;
            1:       opc = OP_SW;
            2:       opc = OP_R;
            3:       opc = OP_BEQ;
            4:       opc = OP_ADDI;
            5:       opc = OP_J;
            default: opc = 6'($urandom_range(0, 63));
         endcase
         run_instr(k, opc);
      end
   endtask

   task automatic mid_reset(input int k);
      bit halted;
      halted = build(k, OP_LW);
      // Stop the lw on its second MEMRD cycle (after FETCH x L, DECODE, MEMADR, one MEMRD).
      for (int i = 0; i < int'(LATS[k*4 +: 4]) + 3; i++)
         step(k, sched[i].v, sched[i].real_op ? OP_LW : 6'($urandom_range(0, 63)), 1'b0,
              1'b1, $sformatf("midrst_c%0d", i));
      step(k, o(3, 2'b01, 2'b00, 2'b00, 9'b0, 1'b0, 1'b0), OP_LW, 1'b1, 1'b1, "midrst_hi");
   endtask

   initial begin
      rst_s  = 3'b111;
      op_all = '0;
      @(posedge clk);
      #1;

      // Instance 0: L=3, all features, halting trap.
      do_reset(0, -1);
      run_instr(0, OP_LW);
      mid_reset(0);
      run_instr(0, OP_LW);
      run_instr(0, OP_ADDI);
      run_instr(0, OP_J);
      run_instr(0, OP_R);
      run_instr(0, OP_BEQ);
      run_instr(0, OP_SW);
      run_random(0, 12);
      run_instr(0, 6'b111111);
      rst_s[0] = 1'b1;

      // Instance 1: L=1, ADDI disabled, non-halting trap.
      do_reset(1, -1);
      run_instr(1, OP_R);
      run_instr(1, OP_BEQ);
      run_instr(1, OP_J);
      run_instr(1, OP_ADDI);
      run_instr(1, OP_LW);
      run_random(1, 12);
      rst_s[1] = 1'b1;

      // Instance 2: L=2, ADDI and J disabled, halting trap.
      do_reset(2, -1);
      run_instr(2, OP_SW);
      run_instr(2, OP_LW);
      run_instr(2, OP_J);
      run_random(2, 12);
      run_instr(2, OP_ADDI);
      rst_s[2] = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
